// File: rtl/poker_table_ctrl_if.sv
// Bundle between the game controller and its environment (dealer, player array, renderer).
// master: environment side, drives the controls, banks and cards.
// slave:  controller side, drives latched cards, deal pulse and game status.
interface poker_table_ctrl_if #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned BANK_W      = 8,
  parameter int unsigned CARD_W      = 6,
  parameter int unsigned HCNT_W      = 8,
  parameter int unsigned IDX_W       = 2
);
  localparam int unsigned CardsW = (2 * NUM_PLAYERS + 5) * CARD_W;

  logic                          start_game;
  logic                          next_hand_user;
  logic                          done_draw_screen;
  logic                          hand_done;
  logic [NUM_PLAYERS*BANK_W-1:0] banks;
  logic                          change;
  logic [CardsW-1:0]             cards_in;
  logic [CardsW-1:0]             cards_out;
  logic                          frame_tog;
  logic                          next_hand;
  logic [NUM_PLAYERS-1:0]        active_mask;
  logic [IDX_W-1:0]              button;
  logic [HCNT_W-1:0]             hand_count;
  logic                          game_over;
  logic [IDX_W-1:0]              winner;
  logic                          winner_valid;
  logic [2:0]                    state;

  modport master (
    output start_game, next_hand_user, done_draw_screen, hand_done, banks, change, cards_in,
    input  cards_out, frame_tog, next_hand, active_mask, button, hand_count, game_over,
           winner, winner_valid, state
  );

  modport slave (
    input  start_game, next_hand_user, done_draw_screen, hand_done, banks, change, cards_in,
    output cards_out, frame_tog, next_hand, active_mask, button, hand_count, game_over,
           winner, winner_valid, state
  );
endinterface

// File: rtl/poker_table_ctrl.sv
// N-player game sequencer: start, press/release per hand, deal pulse, wait for hand end,
// bust elimination with dealer-button rotation, and screen-redraw handshake. Independently
// latches dealer cards into a display-stable bank on every change strobe.
// Ports: clk_i, rst_ni (synchronous, active-low), bus (slave side of poker_table_ctrl_if).
// All outputs are registered.
module poker_table_ctrl #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned BANK_W      = 8,
  parameter int unsigned CARD_W      = 6,
  parameter int unsigned HCNT_W      = 8,
  parameter int unsigned IDX_W       = 2
) (
  input logic             clk_i,
  input logic             rst_ni,
  poker_table_ctrl_if.slave bus
);
  localparam int unsigned CardsW = (2 * NUM_PLAYERS + 5) * CARD_W;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StPress   = 3'd1;
  localparam logic [2:0] StRelease = 3'd2;
  localparam logic [2:0] StDeal    = 3'd3;
  localparam logic [2:0] StHand    = 3'd4;
  localparam logic [2:0] StCheck   = 3'd5;
  localparam logic [2:0] StDraw    = 3'd6;
  localparam logic [2:0] StOver    = 3'd7;

  logic [2:0]             state_q, state_d;
  logic [NUM_PLAYERS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]       button_q, button_d;
  logic [HCNT_W-1:0]      hcnt_q, hcnt_d;
  logic                   over_q, over_d;
  logic [IDX_W-1:0]       winner_q, winner_d;
  logic                   wvalid_q, wvalid_d;
  logic                   next_hand_q, next_hand_d;
  logic [CardsW-1:0]      cards_q, cards_d;
  logic                   tog_q, tog_d;

  logic [NUM_PLAYERS-1:0] new_mask;
  logic [IDX_W:0]         alive_cnt;
  logic [IDX_W-1:0]       next_btn;
  logic [IDX_W-1:0]       srch_idx;
  logic                   found;
  logic [IDX_W-1:0]       win_idx;

  // Survivor analysis; only consumed in StCheck.
  always_comb begin
    new_mask  = '0;
    alive_cnt = '0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      new_mask[i] = mask_q[i] & (|bus.banks[i*BANK_W +: BANK_W]);
      alive_cnt   = alive_cnt + {{IDX_W{1'b0}}, new_mask[i]};
      if (new_mask[i]) win_idx = IDX_W'(i);
    end
  end

  // Next surviving seat strictly after the current button, searching upward with wrap.
  always_comb begin
    next_btn = button_q;
    srch_idx = '0;
    found    = 1'b0;
    for (int unsigned k = 1; k < NUM_PLAYERS; k++) begin
      srch_idx = IDX_W'((32'(button_q) + k) % NUM_PLAYERS);
      if (!found && new_mask[srch_idx]) begin
        next_btn = srch_idx;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    button_d    = button_q;
    hcnt_d      = hcnt_q;
    over_d      = over_q;
    winner_d    = winner_q;
    wvalid_d    = wvalid_q;
    next_hand_d = 1'b0;

    case (state_q)
      StIdle, StOver: begin
        if (bus.start_game) begin
          state_d  = StPress;
          mask_d   = '1;
          button_d = '0;
          hcnt_d   = '0;
          over_d   = 1'b0;
          wvalid_d = 1'b0;
        end
      end
      StPress:   if (bus.next_hand_user) state_d = StRelease;
      StRelease: if (!bus.next_hand_user) state_d = StDeal;
      StDeal: begin
        state_d     = StHand;
        next_hand_d = 1'b1;
        if (hcnt_q != '1) hcnt_d = hcnt_q + HCNT_W'(1);
      end
      StHand: begin
        // next_hand_q marks the first HAND cycle; a stale hand_done level is ignored there.
        if (!next_hand_q && bus.hand_done) state_d = StCheck;
      end
      StCheck: begin
        mask_d = new_mask;
        if (alive_cnt >= (IDX_W+1)'(2)) begin
          state_d  = StDraw;
          button_d = next_btn;
        end else if (alive_cnt == (IDX_W+1)'(1)) begin
          state_d  = StOver;
          winner_d = win_idx;
          wvalid_d = 1'b1;
          over_d   = 1'b1;
        end else begin
          state_d  = StOver;
          winner_d = '0;
          wvalid_d = 1'b0;
          over_d   = 1'b1;
        end
      end
      StDraw:  if (bus.done_draw_screen) state_d = StPress;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cards_d = cards_q;
    tog_d   = tog_q;
    if (bus.change) begin
      cards_d = bus.cards_in;
      tog_d   = ~tog_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      button_q    <= '0;
      hcnt_q      <= '0;
      over_q      <= 1'b0;
      winner_q    <= '0;
      wvalid_q    <= 1'b0;
      next_hand_q <= 1'b0;
      cards_q     <= '0;
      tog_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      button_q    <= button_d;
      hcnt_q      <= hcnt_d;
      over_q      <= over_d;
      winner_q    <= winner_d;
      wvalid_q    <= wvalid_d;
      next_hand_q <= next_hand_d;
      cards_q     <= cards_d;
      tog_q       <= tog_d;
    end
  end

  assign bus.cards_out    = cards_q;
  assign bus.frame_tog    = tog_q;
  assign bus.next_hand    = next_hand_q;
  assign bus.active_mask  = mask_q;
  assign bus.button       = button_q;
  assign bus.hand_count   = hcnt_q;
  assign bus.game_over    = over_q;
  assign bus.winner       = winner_q;
  assign bus.winner_valid = wvalid_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_poker_table_ctrl.sv
// Directed bench: a 4-seat instance for the main game flow and card latch, and a 2-seat
// instance with a 2-bit hand counter for button alternation and counter saturation.
module tb_poker_table_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  poker_table_ctrl_if #(.NUM_PLAYERS(4), .BANK_W(8), .CARD_W(6), .HCNT_W(8), .IDX_W(2)) bus_a ();
  poker_table_ctrl_if #(.NUM_PLAYERS(2), .BANK_W(8), .CARD_W(6), .HCNT_W(2), .IDX_W(1)) bus_b ();

  poker_table_ctrl #(.NUM_PLAYERS(4), .BANK_W(8), .CARD_W(6), .HCNT_W(8), .IDX_W(2)) u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_a)
  );

  poker_table_ctrl #(.NUM_PLAYERS(2), .BANK_W(8), .CARD_W(6), .HCNT_W(2), .IDX_W(1)) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives seat A from PRESS through to the registered CHECK state.
  task automatic run_hand_a();
    bus_a.next_hand_user = 1'b1; tick();
    bus_a.next_hand_user = 1'b0; tick();
    bus_a.hand_done = 1'b1; tick();
    tick();
    tick();
    bus_a.hand_done = 1'b0;
  endtask

  task automatic run_hand_b();
    bus_b.next_hand_user = 1'b1; tick();
    bus_b.next_hand_user = 1'b0; tick();
    bus_b.hand_done = 1'b1; tick();
    tick();
    tick();
    bus_b.hand_done = 1'b0;
  endtask

  task automatic reset_and_start_a();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    bus_a.start_game = 1'b1; tick();
    bus_a.start_game = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.change = 1'b1;
    bus_a.start_game = 1'b1;
    bus_a.cards_in = 78'h2a_5555_aaaa_1234_5678;
    tick(); tick();
    n_checks++;
    if (bus_a.state !== 3'd0) begin
      n_errors++; $display("FAIL reset_state: got %0d expected 0", bus_a.state);
    end
    n_checks++;
    if (bus_a.frame_tog !== 1'b0) begin
      n_errors++; $display("FAIL reset_frame_tog: got %0b expected 0", bus_a.frame_tog);
    end
    n_checks++;
    if (bus_a.cards_out !== 78'h0) begin
      n_errors++; $display("FAIL reset_cards_out: got %h expected 0", bus_a.cards_out);
    end
    n_checks++;
    if ({bus_a.active_mask, bus_a.button, bus_a.hand_count, bus_a.game_over, bus_a.winner,
         bus_a.winner_valid, bus_a.next_hand} !== 19'h0) begin
      n_errors++; $display("FAIL reset_status: mask %b btn %0d hc %0d over %b win %0d wv %b nh %b expected all 0",
        bus_a.active_mask, bus_a.button, bus_a.hand_count, bus_a.game_over, bus_a.winner,
        bus_a.winner_valid, bus_a.next_hand);
    end
    bus_a.change = 1'b0;
    bus_a.start_game = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_normal_hand();
    bus_a.banks = {8'd100, 8'd100, 8'd100, 8'd100};
    bus_a.start_game = 1'b1; tick();
    bus_a.start_game = 1'b0;
    n_checks++;
    if (bus_a.state !== 3'd1 || bus_a.active_mask !== 4'b1111 || bus_a.hand_count !== 8'd0) begin
      n_errors++; $display("FAIL start: state %0d mask %b hc %0d expected 1 1111 0",
        bus_a.state, bus_a.active_mask, bus_a.hand_count);
    end
    bus_a.next_hand_user = 1'b1; tick();
    n_checks++;
    if (bus_a.state !== 3'd2) begin
      n_errors++; $display("FAIL press: got %0d expected 2", bus_a.state);
    end
    bus_a.next_hand_user = 1'b0; tick();
    bus_a.hand_done = 1'b1;
    n_checks++;
    if (bus_a.state !== 3'd3 || bus_a.next_hand !== 1'b0) begin
      n_errors++; $display("FAIL release: state %0d nh %b expected 3 0", bus_a.state, bus_a.next_hand);
    end
    tick();
    n_checks++;
    if (bus_a.state !== 3'd4 || bus_a.next_hand !== 1'b1 || bus_a.hand_count !== 8'd1) begin
      n_errors++; $display("FAIL deal: state %0d nh %b hc %0d expected 4 1 1",
        bus_a.state, bus_a.next_hand, bus_a.hand_count);
    end
    tick();
    n_checks++;
    if (bus_a.state !== 3'd4 || bus_a.next_hand !== 1'b0) begin
      n_errors++; $display("FAIL stale_guard: state %0d nh %b expected 4 0", bus_a.state, bus_a.next_hand);
    end
    tick();
    n_checks++;
    if (bus_a.state !== 3'd5 || bus_a.next_hand !== 1'b0) begin
      n_errors++; $display("FAIL to_check: state %0d nh %b expected 5 0", bus_a.state, bus_a.next_hand);
    end
    bus_a.hand_done = 1'b0;
    tick();
    n_checks++;
    if (bus_a.state !== 3'd6 || bus_a.button !== 2'd1 || bus_a.active_mask !== 4'b1111) begin
      n_errors++; $display("FAIL draw: state %0d btn %0d mask %b expected 6 1 1111",
        bus_a.state, bus_a.button, bus_a.active_mask);
    end
    bus_a.start_game = 1'b1; tick();
    bus_a.start_game = 1'b0;
    n_checks++;
    if (bus_a.state !== 3'd6) begin
      n_errors++; $display("FAIL draw_wait: got %0d expected 6", bus_a.state);
    end
    bus_a.done_draw_screen = 1'b1; tick();
    bus_a.done_draw_screen = 1'b0;
    n_checks++;
    if (bus_a.state !== 3'd1 || bus_a.hand_count !== 8'd1) begin
      n_errors++; $display("FAIL redraw: state %0d hc %0d expected 1 1", bus_a.state, bus_a.hand_count);
    end
  endtask

  task automatic test_elimination();
    reset_and_start_a();
    run_hand_a();
    bus_a.banks = {8'd40, 8'd0, 8'd0, 8'd200};
    tick();
    n_checks++;
    if (bus_a.state !== 3'd6 || bus_a.active_mask !== 4'b1001 || bus_a.button !== 2'd3) begin
      n_errors++; $display("FAIL elim: state %0d mask %b btn %0d expected 6 1001 3",
        bus_a.state, bus_a.active_mask, bus_a.button);
    end
    bus_a.done_draw_screen = 1'b1; tick();
    bus_a.done_draw_screen = 1'b0;
    run_hand_a();
    bus_a.banks = {8'd40, 8'd50, 8'd0, 8'd200};
    tick();
    n_checks++;
    if (bus_a.active_mask !== 4'b1001 || bus_a.button !== 2'd0 || bus_a.hand_count !== 8'd2) begin
      n_errors++; $display("FAIL no_reentry: mask %b btn %0d hc %0d expected 1001 0 2",
        bus_a.active_mask, bus_a.button, bus_a.hand_count);
    end
    bus_a.done_draw_screen = 1'b1; tick();
    bus_a.done_draw_screen = 1'b0;
  endtask

  task automatic test_game_end();
    reset_and_start_a();
    run_hand_a();
    bus_a.banks = {8'd0, 8'd77, 8'd0, 8'd0};
    tick();
    n_checks++;
    if (bus_a.state !== 3'd7 || bus_a.game_over !== 1'b1 || bus_a.winner !== 2'd2 ||
        bus_a.winner_valid !== 1'b1 || bus_a.active_mask !== 4'b0100) begin
      n_errors++; $display("FAIL game_end: state %0d over %b win %0d wv %b mask %b expected 7 1 2 1 0100",
        bus_a.state, bus_a.game_over, bus_a.winner, bus_a.winner_valid, bus_a.active_mask);
    end
    bus_a.hand_done = 1'b1; bus_a.next_hand_user = 1'b1; tick();
    bus_a.hand_done = 1'b0; bus_a.next_hand_user = 1'b0;
    n_checks++;
    if (bus_a.state !== 3'd7 || bus_a.game_over !== 1'b1 || bus_a.winner !== 2'd2) begin
      n_errors++; $display("FAIL over_hold: state %0d over %b win %0d expected 7 1 2",
        bus_a.state, bus_a.game_over, bus_a.winner);
    end
    bus_a.start_game = 1'b1; tick();
    bus_a.start_game = 1'b0;
    n_checks++;
    if (bus_a.state !== 3'd1 || bus_a.active_mask !== 4'b1111 || bus_a.hand_count !== 8'd0 ||
        bus_a.game_over !== 1'b0 || bus_a.winner_valid !== 1'b0 || bus_a.button !== 2'd0) begin
      n_errors++; $display("FAIL restart: state %0d mask %b hc %0d over %b wv %b btn %0d expected 1 1111 0 0 0 0",
        bus_a.state, bus_a.active_mask, bus_a.hand_count, bus_a.game_over, bus_a.winner_valid,
        bus_a.button);
    end
  endtask

  task automatic test_double_bust();
    run_hand_a();
    bus_a.banks = '0;
    tick();
    n_checks++;
    if (bus_a.state !== 3'd7 || bus_a.game_over !== 1'b1 || bus_a.winner_valid !== 1'b0 ||
        bus_a.winner !== 2'd0 || bus_a.active_mask !== 4'b0000) begin
      n_errors++; $display("FAIL double_bust: state %0d over %b wv %b win %0d mask %b expected 7 1 0 0 0000",
        bus_a.state, bus_a.game_over, bus_a.winner_valid, bus_a.winner, bus_a.active_mask);
    end
  endtask

  task automatic test_card_latch();
    logic [77:0] vecs [3];
    logic        exp_tog;
    vecs[0] = 78'h01_0203_0405_0607_0809;
    vecs[1] = 78'h11_1213_1415_1617_1819;
    vecs[2] = 78'h21_2223_2425_2627_2829;
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    exp_tog = 1'b0;
    bus_a.change = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_a.cards_in = vecs[i];
      tick();
      exp_tog = ~exp_tog;
      n_checks++;
      if (bus_a.cards_out !== vecs[i] || bus_a.frame_tog !== exp_tog) begin
        n_errors++; $display("FAIL latch_%0d: cards %h tog %b expected %h %b",
          i, bus_a.cards_out, bus_a.frame_tog, vecs[i], exp_tog);
      end
    end
    bus_a.change = 1'b0;
    bus_a.cards_in = 78'h3f_ffff_ffff_ffff_ffff;
    tick(); tick();
    n_checks++;
    if (bus_a.cards_out !== vecs[2] || bus_a.frame_tog !== 1'b1) begin
      n_errors++; $display("FAIL latch_hold: cards %h tog %b expected %h 1",
        bus_a.cards_out, bus_a.frame_tog, vecs[2]);
    end
  endtask

  task automatic test_two_player();
    logic [1:0] exp_hc [5];
    logic       exp_btn [5];
    exp_hc  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    exp_btn = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    bus_b.banks = {8'd9, 8'd9};
    bus_b.start_game = 1'b1; tick();
    bus_b.start_game = 1'b0;
    for (int h = 0; h < 5; h++) begin
      run_hand_b();
      tick();
      n_checks++;
      if (bus_b.state !== 3'd6 || bus_b.hand_count !== exp_hc[h] || bus_b.button !== exp_btn[h]) begin
        n_errors++; $display("FAIL two_player_hand%0d: state %0d hc %0d btn %0d expected 6 %0d %0d",
          h, bus_b.state, bus_b.hand_count, bus_b.button, exp_hc[h], exp_btn[h]);
      end
      bus_b.done_draw_screen = 1'b1; tick();
      bus_b.done_draw_screen = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus_a.start_game = 1'b0; bus_a.next_hand_user = 1'b0; bus_a.done_draw_screen = 1'b0;
    bus_a.hand_done = 1'b0; bus_a.banks = '0; bus_a.change = 1'b0; bus_a.cards_in = '0;
    bus_b.start_game = 1'b0; bus_b.next_hand_user = 1'b0; bus_b.done_draw_screen = 1'b0;
    bus_b.hand_done = 1'b0; bus_b.banks = '0; bus_b.change = 1'b0; bus_b.cards_in = '0;

    test_reset();
    test_normal_hand();
    test_elimination();
    test_game_end();
    test_double_bust();
    test_card_latch();
    test_two_player();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/poker_table_ctrl.md
Name: poker_table_ctrl

Overview:
- N-player successor to the two-player game sequencer.
- Runs the game-level FSM: start, user press/release per hand, deal pulse, wait for hand end, bust elimination, screen-redraw handshake.
- Also tracks the active-player mask, dealer button rotation and hand count.
- Latches dealer card outputs into a display-stable register bank on each dealer `change` strobe.
- Sits between the dealer/player array and the VGA renderer.

Parameters:
- NUM_PLAYERS, 4, number of seats (2..8)
- BANK_W, 8, width of each player bank value
- CARD_W, 6, width of one card code
- HCNT_W, 8, width of hand counter
- IDX_W, 2, seat index width; must equal ceil(log2(NUM_PLAYERS)), minimum 1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- start_game  in  1  level; sampled in IDLE/OVER
- next_hand_user  in  1  user button; a press then release advances to the next hand
- done_draw_screen  in  1  renderer finished redrawing results
- hand_done  in  1  dealer reports hand settled
- banks  in  NUM_PLAYERS*BANK_W  seat i at bits [i*BANK_W +: BANK_W]
- change  in  1  dealer card-update strobe
- cards_in  in  (2*NUM_PLAYERS+5)*CARD_W  hole cards seat-major, then flop0..2, turn, river
- cards_out  out  (2*NUM_PLAYERS+5)*CARD_W  registered copy of cards_in
- frame_tog  out  1  toggles on every latch
- next_hand  out  1  one-cycle deal-start pulse to dealer
- active_mask  out  NUM_PLAYERS  bit i = seat i still in game
- button  out  IDX_W  dealer button seat
- hand_count  out  HCNT_W  hands dealt this game
- game_over  out  1  high while in OVER
- winner  out  IDX_W  surviving seat index
- winner_valid  out  1  exactly one survivor
- state  out  3  FSM state, for debug

Behaviour:
- Reset (rst=0 at a clk edge) forces all registered outputs to 0 and state to IDLE, overriding any other event in that cycle.
- Reset mid-hand abandons the game immediately.
- All outputs are registered.
- State encodings: IDLE=0, PRESS=1, RELEASE=2, DEAL=3, HAND=4, CHECK=5, DRAW=6, OVER=7.
- IDLE, start_game=1 → PRESS. Same edge: active_mask←all ones, button←0, hand_count←0, game_over←0, winner_valid←0.
- PRESS, next_hand_user=1 → RELEASE.
- RELEASE, next_hand_user=0 → DEAL.
- DEAL → HAND (1 cycle). hand_count←hand_count+1, saturating at all ones.
- next_hand is 1 for exactly the first HAND cycle; 0 in every other cycle.
- hand_done is ignored during that first HAND cycle (stale-level guard).
- hand_done is ignored in every state except HAND.
- HAND, hand_done=1 (from the 2nd HAND cycle on) → CHECK.
- CHECK (1 cycle):
  - new_mask = active_mask AND (bank_i != 0) per seat; active_mask←new_mask.
  - Seats already eliminated never re-enter.
  - popcount(new_mask) ≥ 2 → DRAW. button←next set bit of new_mask strictly after current button, searching upward with wrap.
  - popcount(new_mask) = 1 → OVER. winner←that index, winner_valid←1, game_over←1.
  - popcount(new_mask) = 0 → OVER. winner←0, winner_valid←0, game_over←1.
- DRAW, done_draw_screen=1 → PRESS.
- OVER: game_over held 1; all outputs frozen.
  - start_game=1 → PRESS with the same initialisation as from IDLE.
- start_game is ignored in PRESS..DRAW.
- Card latch is independent of the FSM and active in every state.
  - change=1: cards_out←cards_in, frame_tog←~frame_tog, in that same edge.
  - change held for k cycles gives k latches and k toggles.
- NUM_PLAYERS=2 must reproduce two-player semantics: button alternates 0,1,0,…

Test Plan:
- Reset: rst=0 for 2 cycles with change=1 and start_game=1 → all outputs 0, state=0, frame_tog=0.
- Normal hand: start_game, press/release, hand_done=1 held high from DEAL onward → next_hand high exactly 1 cycle, hand_count=1, state reaches 5 then 6, button=1.
- Elimination/rotation: banks={seat3=40, seat2=0, seat1=0, seat0=200}, button=0 at CHECK → active_mask=4'b1001, button=3. Next hand with seat2 bank=50 → active_mask stays 4'b1001 (no re-entry).
- Game end: only seat2 bank nonzero at CHECK → state=7, game_over=1, winner=2, winner_valid=1. start_game → state=1, active_mask=4'b1111, hand_count=0, game_over=0.
- Double bust: all banks 0 at CHECK → game_over=1, winner_valid=0, winner=0.
- Card latch: change pulsed 3 cycles with cards_in ramping → cards_out follows the last value, frame_tog toggled 3×. hand_count saturation: HCNT_W=2 over 5 hands → stays 3.
